instr_fetch_queue: RTL and testbench

- Fetch stage directly upstream of the 8-bit processor core's decode/execute.
- Generates word addresses to a synchronous instruction memory with 1-cycle read latency, and buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to the core over a valid/ready handshake.
- Supports branch/jump redirect (flush) and a halt input that stops new fetches.

---
 rtl/instr_fetch_queue.sv | 122 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch address generator with return-data queue
module instr_fetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_rd_en,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     instr_valid,
    output logic [INSTR_W-1:0]       instr_data,
    output logic [ADDR_W-1:0]        instr_pc,
    input  logic                     instr_ready,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     halt,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_L = (PW+2)'(DEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
    logic              inflight_q, inflight_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]       count_q, count_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];

    logic [PW+1:0]     occupancy;
    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;

    // Issue/push/pop decisions; the in-flight read reserves a slot so a push never overflows
    always_comb begin
        occupancy  = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q};
        issue      = rst & ~redirect_valid & ~halt & (occupancy < DEPTH_L);
        push       = inflight_q & ~redirect_valid;
        head_valid = (count_q != '0) & ~redirect_valid;
        pop        = head_valid & instr_ready;
    end

    // Next-state: redirect flushes everything and kills the returning read
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_pc_d   = tag_pc_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                tag_pc_d   = fetch_pc_q;
            end
            if (push) begin
                mem_d[wr_ptr_q] = {imem_rdata, tag_pc_q};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            tag_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    // Output drive: head entry shown only when the queue holds something
    always_comb begin
        imem_rd_en  = issue;
        imem_addr   = fetch_pc_q;
        instr_valid = head_valid;
        instr_data  = (count_q != '0) ? mem_q[rd_ptr_q].instr : '0;
        instr_pc    = (count_q != '0) ? mem_q[rd_ptr_q].pc : '0;
        q_count     = count_q;
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int AW = 8;
    localparam int IW = 16;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic [IW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt = 1'b0;
    logic [2:0]    q_count;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch_queue #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .q_count(q_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: contents are A000|addr, junk when not read
    always @(posedge clk) imem_rdata <= imem_rd_en ? (16'hA000 | {8'h00, imem_addr}) : 16'hDEAD;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: queue of {pc,data}, one pending read, a fetch pointer
    logic [AW+IW-1:0] mq[$];
    int               m_pend = 0;
    logic [AW-1:0]    m_pend_pc = '0;
    logic [AW-1:0]    m_pc = '0;
    int               iss_log[$];
    logic [AW+IW-1:0] pop_log[$];

    always @(negedge rst) begin
        mq.delete();
        m_pend = 0;
        m_pc   = 8'h00;
    end

    always @(negedge clk) begin
        logic e_rd, e_val;
        e_rd  = rst && !redirect_valid && !halt && (mq.size() + m_pend < D);
        e_val = (mq.size() != 0) && !redirect_valid;
        check("rd_en", 32'(imem_rd_en), 32'(e_rd));
        if (e_rd) check("addr", 32'(imem_addr), 32'(m_pc));
        check("valid", 32'(instr_valid), 32'(e_val));
        check("count", 32'(q_count), 32'(mq.size()));
        check("head_pc", 32'(instr_pc), (mq.size() != 0) ? 32'(mq[0][AW+IW-1:IW]) : 32'h0);
        check("head_data", 32'(instr_data), (mq.size() != 0) ? 32'(mq[0][IW-1:0]) : 32'h0);
        if (imem_rd_en) iss_log.push_back(int'(imem_addr));
        if (instr_valid && instr_ready) pop_log.push_back({instr_pc, instr_data});
        if (rst) begin
            if (redirect_valid) begin
                mq.delete();
                m_pend = 0;
                m_pc   = redirect_pc;
            end else begin
                if (e_val && instr_ready) void'(mq.pop_front());
                if (m_pend != 0) mq.push_back({m_pend_pc, 16'hA000 | {8'h00, m_pend_pc}});
                m_pend = e_rd ? 1 : 0;
                if (e_rd) begin
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 8'd1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        iss_log.delete();
        pop_log.delete();
    endtask

    function automatic logic [31:0] iss_at(input int i);
        return (i < iss_log.size()) ? 32'(iss_log[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (i < pop_log.size()) ? 32'(pop_log[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [7:0] wrap_pc [4];
        bit         seq_ok;
        wrap_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};

        // Reset state
        repeat (3) step();
        check("rst_count", 32'(q_count), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_rd_en", 32'(imem_rd_en), 32'd0);

        // Streaming from reset
        rst = 1'b1;
        clear_logs();
        repeat (6) step();
        check("stream_iss_n", 32'(iss_log.size()), 32'd6);
        check("stream_iss0", iss_at(0), 32'h0);
        check("stream_iss5", iss_at(5), 32'h5);
        check("stream_pop_n", 32'(pop_log.size()), 32'd4);
        check("stream_pop0", pop_at(0), 32'h00A000);
        check("stream_pop3", pop_at(3), 32'h03A003);

        // Backpressure from release
        rst = 1'b0;
        step();
        step();
        instr_ready = 1'b0;
        rst = 1'b1;
        clear_logs();
        repeat (8) step();
        check("bp_iss_n", 32'(iss_log.size()), 32'd4);
        check("bp_iss3", iss_at(3), 32'h3);
        check("bp_count", 32'(q_count), 32'd4);
        check("bp_rd_en", 32'(imem_rd_en), 32'd0);
        instr_ready = 1'b1;
        clear_logs();
        repeat (6) step();
        for (int i = 0; i < 4; i++) check("bp_drain_pc", pop_at(i) >> IW, 32'(i));
        check("bp_resume", iss_at(0), 32'h4);

        // Redirect with a read in flight
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect_valid = 1'b0;
        check("redir_count", 32'(q_count), 32'd0);
        repeat (6) step();
        check("redir_iss0", iss_at(0), 32'h40);
        check("redir_pop0", pop_at(0), 32'h40A040);
        check("redir_pop1", pop_at(1) >> IW, 32'h41);

        // Wrap of the fetch address
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        step();
        redirect_valid = 1'b0;
        repeat (8) step();
        for (int i = 0; i < 4; i++) check("wrap_pc", pop_at(i) >> IW, 32'(wrap_pc[i]));

        // Halt mid-stream
        clear_logs();
        repeat (3) step();
        halt = 1'b1;
        repeat (5) step();
        check("halt_drained", 32'(q_count), 32'd0);
        check("halt_rd_en", 32'(imem_rd_en), 32'd0);
        halt = 1'b0;
        repeat (6) step();
        check("halt_iss_n", 32'(iss_log.size()), 32'd9);
        seq_ok = 1'b1;
        for (int i = 1; i < iss_log.size(); i++)
            if (iss_log[i] != ((iss_log[i-1] + 1) & 8'hFF)) seq_ok = 1'b0;
        check("halt_seq", 32'(seq_ok), 32'd1);

        // Reset while three entries are queued
        instr_ready = 1'b0;
        for (int i = 0; i < 10 && q_count != 3'd3; i++) step();
        check("mid_count3", 32'(q_count), 32'd3);
        rst = 1'b0;
        #1;
        check("mid_rst_count", 32'(q_count), 32'd0);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_rd_en", 32'(imem_rd_en), 32'd0);
        step();
        step();
        rst = 1'b1;
        instr_ready = 1'b1;
        clear_logs();
        repeat (5) step();
        check("mid_restart_iss0", iss_at(0), 32'h0);
        check("mid_restart_pop0", pop_at(0), 32'h00A000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
